// File: rtl/spiflash_line_cache.sv
// Direct-mapped read cache in front of the SPI flash controller.
// A miss fetches the whole 16-byte line as four sequential word reads.
module spiflash_line_cache #(
   parameter int LINES = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        valid,
   output logic        ready,
   input  logic [23:0] addr,
   output logic [31:0] rdata,
   input  logic        invalidate,
   output logic        flash_valid,
   input  logic        flash_ready,
   output logic [23:0] flash_addr,
   input  logic [31:0] flash_rdata
);

   localparam int IDX  = $clog2(LINES);
   localparam int TAGW = 20 - IDX;

   typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

   state_t state, state_next;

   logic [31:0]     words [LINES][4];
   logic [TAGW-1:0] tags  [LINES];
   logic [LINES-1:0] line_valid;

   logic [1:0]      cnt;
   logic [19:0]     base;
   logic [1:0]      fill_off;
   logic            inv_flag;

   logic [1:0]      offset;
   logic [IDX-1:0]  index;
   logic [TAGW-1:0] tag;
   logic [IDX-1:0]  fill_idx;
   logic            hit;
   logic            fill_done;
   logic            unused_addr_bits;

   assign offset           = addr[3:2];
   assign index            = addr[IDX+3:4];
   assign tag              = addr[23:IDX+4];
   assign fill_idx         = base[IDX-1:0];
   assign hit              = line_valid[index] && (tags[index] == tag) && !invalidate;
   assign fill_done        = (state == FILL) && flash_ready && (cnt == 2'd3);
   assign unused_addr_bits = ^addr[1:0];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (valid) state_next = hit ? RESP : FILL;
         FILL: if (fill_done) state_next = RESP;
         RESP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ready       <= 1'b0;
         rdata       <= 32'h0;
         flash_valid <= 1'b0;
         flash_addr  <= 24'h0;
         line_valid  <= '0;
         cnt         <= 2'd0;
         inv_flag    <= 1'b0;
         base        <= 20'h0;
         fill_off    <= 2'd0;
      end else begin
         ready <= 1'b0;
         // A late invalidate (flag or this very cycle) keeps the new line invalid.
         if (invalidate) begin
            line_valid <= '0;
         end else if (fill_done && !inv_flag) begin
            line_valid[fill_idx] <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (valid) begin
                  if (hit) begin
                     rdata <= words[index][offset];
                     ready <= 1'b1;
                  end else begin
                     base        <= addr[23:4];
                     fill_off    <= offset;
                     flash_addr  <= {addr[23:4], 4'h0};
                     flash_valid <= 1'b1;
                     cnt         <= 2'd0;
                     inv_flag    <= 1'b0;
                  end
               end
            end
            FILL: begin
               if (invalidate) inv_flag <= 1'b1;
               if (flash_ready) begin
                  if (cnt == fill_off) rdata <= flash_rdata;
                  // Concatenation keeps the top line from carrying into 0x000000.
                  flash_addr <= {base, cnt + 2'd1, 2'b00};
                  cnt        <= cnt + 2'd1;
                  if (cnt == 2'd3) begin
                     flash_valid <= 1'b0;
                     ready       <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (resetn && (state == FILL) && flash_ready) begin
         words[fill_idx][cnt] <= flash_rdata;
      end
      if (resetn && fill_done) begin
         tags[fill_idx] <= base[19:IDX];
      end
   end

endmodule

// File: tb/tb_spiflash_line_cache.sv
// Bench for spiflash_line_cache: directed scenarios followed by random reads,
// compared against a line-level hit/miss model and a flash content function.
module tb_spiflash_line_cache;

   localparam int LINES = 8;
   localparam int IDX   = 3;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        valid = 1'b0;
   logic [23:0] addr = 24'h0;
   logic        invalidate = 1'b0;
   logic        flash_ready = 1'b0;
   logic [31:0] flash_rdata = 32'h0;
   logic        ready;
   logic [31:0] rdata;
   logic        flash_valid;
   logic [23:0] flash_addr;

   int          checks = 0;
   int          errors = 0;
   bit          patternMode = 1'b1;
   logic [23:0] fillAddrs [$];
   bit          mv [LINES];
   int          mt [LINES];

   spiflash_line_cache #(.LINES(LINES)) dut (
      .clk(clk), .resetn(resetn), .valid(valid), .ready(ready), .addr(addr),
      .rdata(rdata), .invalidate(invalidate), .flash_valid(flash_valid),
      .flash_ready(flash_ready), .flash_addr(flash_addr), .flash_rdata(flash_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [23:0] a);
      if (patternMode) return 32'hA0 + {30'h0, a[3:2]};
      return ({8'h0, a[23:2], 2'b00} * 32'h9E3779B1) ^ 32'h3C6EF372;
   endfunction

   function automatic void clearModel();
      foreach (mv[i]) mv[i] = 1'b0;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Flash controller stand-in: acknowledges with random gaps, logs each address served.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (resetn && flash_valid && ($urandom_range(0, 3) != 0)) begin
            flash_ready = 1'b1;
            flash_rdata = memWord(flash_addr);
            fillAddrs.push_back(flash_addr);
         end else begin
            flash_ready = 1'b0;
            flash_rdata = $urandom;
         end
      end
   end

   task automatic pulseInvalidate();
      @(negedge clk);
      invalidate = 1'b1;
      @(negedge clk);
      invalidate = 1'b0;
      clearModel();
   endtask

   // invAt > 0: pulse invalidate once that many words have been delivered.
   // invAt < 0: invalidate coincides with the lookup. rstAt > 0: reset after that many words.
   task automatic applyStimulus(input logic [23:0] a, input int invAt, input int rstAt, input string tag);
      int          idx;
      int          t;
      bit          expMiss;
      int          cyc;
      bit          gotReady;
      bit          sawFv;
      bit          gap;
      bit          invSeen;
      bit          aborted;
      logic [31:0] got;
      logic [23:0] lineBase;
      idx      = int'(a >> 4) % LINES;
      t        = int'(a >> (4 + IDX));
      lineBase = a & 24'hFFFFF0;
      if (invAt < 0) clearModel();
      expMiss  = !(mv[idx] && (mt[idx] == t));
      cyc = 0; gotReady = 0; sawFv = 0; gap = 0; invSeen = 0; aborted = 0; got = 32'h0;
      fillAddrs.delete();
      @(negedge clk);
      valid = 1'b1;
      addr  = a;
      if (invAt < 0) invalidate = 1'b1;
      while (!gotReady && !aborted && cyc < 60) begin
         @(negedge clk);
         cyc++;
         invalidate = 1'b0;
         if (ready) begin
            gotReady = 1;
            got      = rdata;
            valid    = 1'b0;
         end else begin
            if (flash_valid) sawFv = 1;
            else if (sawFv) gap = 1;
            if (invAt > 0 && !invSeen && fillAddrs.size() == invAt) begin
               invalidate = 1'b1;
               invSeen    = 1;
            end
            if (rstAt > 0 && fillAddrs.size() == rstAt) begin
               resetn  = 1'b0;
               valid   = 1'b0;
               aborted = 1;
            end
         end
      end
      if (aborted) begin
         @(negedge clk);
         checkOutput({tag, "_rst_ready"}, ready, 0);
         checkOutput({tag, "_rst_fvalid"}, flash_valid, 0);
         resetn = 1'b1;
         clearModel();
         return;
      end
      checkOutput({tag, "_got_ready"}, gotReady, 1);
      if (!gotReady) begin
         valid = 1'b0;
         return;
      end
      checkOutput({tag, "_rdata"}, got, memWord(a & 24'hFFFFFC));
      if (expMiss) begin
         checkOutput({tag, "_fill_cnt"}, fillAddrs.size(), 4);
         for (int k = 0; k < 4 && k < fillAddrs.size(); k++)
            checkOutput($sformatf("%s_faddr%0d", tag, k), fillAddrs[k], lineBase + 24'(4 * k));
         checkOutput({tag, "_fv_gap"}, gap, 0);
      end else begin
         checkOutput({tag, "_hit_lat"}, cyc, 1);
         checkOutput({tag, "_hit_noflash"}, sawFv, 0);
      end
      @(negedge clk);
      checkOutput({tag, "_ready_pulse"}, ready, 0);
      if (invSeen) begin
         clearModel();
      end else if (expMiss) begin
         mv[idx] = 1'b1;
         mt[idx] = t;
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      clearModel();
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_ready", ready, 0);
      checkOutput("reset_rdata", rdata, 32'h0);
      checkOutput("reset_fvalid", flash_valid, 0);
      checkOutput("reset_faddr", flash_addr, 24'h0);
      resetn = 1'b1;

      patternMode = 1'b1;
      applyStimulus(24'h000104, 0, 0, "cold");
      applyStimulus(24'h000100, 0, 0, "hit0");
      applyStimulus(24'h00010C, 0, 0, "hit3");
      applyStimulus(24'h000180, 0, 0, "conflict");
      applyStimulus(24'h000100, 0, 0, "remiss");
      pulseInvalidate();

      patternMode = 1'b0;
      applyStimulus(24'h000248, 1, 0, "invfill");
      applyStimulus(24'h000248, 0, 0, "invrefill");
      applyStimulus(24'h0003C4, 0, 2, "rstfill");
      applyStimulus(24'h0003C4, 0, 0, "rstrefill");
      applyStimulus(24'h0003C8, 0, 0, "rsthit");
      applyStimulus(24'hFFFFFC, 0, 0, "topline");
      applyStimulus(24'hFFFFF0, 0, 0, "tophit");
      applyStimulus(24'h000500, 0, 0, "coinc_fill");
      applyStimulus(24'h000500, -1, 0, "coinc_miss");
      pulseInvalidate();

      for (int n = 0; n < 60; n++) begin
         logic [23:0] ra;
         int          inv;
         ra  = 24'(($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2));
         inv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
         applyStimulus(ra, inv, 0, $sformatf("rnd%0d", n));
         if ($urandom_range(0, 15) == 0) pulseInvalidate();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
